// File: rtl/axi_pack_req_split_pkg.sv
// Shared AXI and packed-AXI types for the strided request splitter:
// burst/size encodings, stride, user sideband, AX channel and descriptor.
package axi_pkg;

    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam burst_t BURST_INCR = 2'b01;

endpackage

package axi_pack_pkg;

    localparam int unsigned StrideWidth   = 32;
    localparam int unsigned ChanAddrWidth = 48;
    localparam int unsigned ChanIdWidth   = 4;
    localparam int unsigned DescCntWidth  = 32;

    typedef logic signed [StrideWidth-1:0] stride_t;

    typedef struct packed {
        stride_t stride;
    } ssr_user_t;

    typedef struct packed {
        logic [ChanIdWidth-1:0]   id;
        logic [ChanAddrWidth-1:0] addr;
        logic [7:0]               len;
        axi_pkg::size_t           size;
        axi_pkg::burst_t          burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               qos;
        logic [3:0]               region;
        logic [5:0]               atop;
        ssr_user_t                user;
    } ax_chan_t;

    typedef struct packed {
        logic [ChanAddrWidth-1:0] addr;
        stride_t                  stride;
        axi_pkg::size_t           size;
        logic [DescCntWidth-1:0]  num;
        logic [ChanIdWidth-1:0]   id;
    } desc_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

endpackage

// File: rtl/axi_pack_req_split_if.sv
// Descriptor-in / packed-AX-out bundle around the request splitter.
// master: descriptor source and AX sink; slave: the splitter side.
interface axi_pack_req_split_if #(
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned AxiIdWidth = 4,
    parameter int unsigned CntWidth   = 32,
    parameter type         ax_chan_t  = axi_pack_pkg::ax_chan_t
);

    logic                    desc_valid;
    logic                    desc_ready;
    logic [AddrWidth-1:0]    desc_addr;
    axi_pack_pkg::stride_t   desc_stride;
    axi_pkg::size_t          desc_size;
    logic [CntWidth-1:0]     desc_num;
    logic [AxiIdWidth-1:0]   desc_id;
    ax_chan_t                ax_chan;
    logic                    ax_valid;
    logic                    ax_ready;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output desc_valid, desc_addr, desc_stride, desc_size,
        output desc_num, desc_id, ax_ready,
        input  desc_ready, ax_chan, ax_valid, busy, done, err
    );

    modport slave (
        input  desc_valid, desc_addr, desc_stride, desc_size,
        input  desc_num, desc_id, ax_ready,
        output desc_ready, ax_chan, ax_valid, busy, done, err
    );

endinterface

// File: rtl/axi_pack_req_split.sv
// Splits a strided element descriptor into packed-AXI bursts of at most
// MaxBeats beats each.
// Ports: clk_i/rst_i (sync active-high); desc_* valid/ready descriptor
// input; ax_chan_o/ax_valid_o/ax_ready_i registered burst output;
// busy_o while issuing, done_o / err_o one-cycle completion/drop pulses.
module axi_pack_req_split
    import axi_pack_pkg::*;
#(
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned AxiIdWidth = 4,
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned MaxBeats   = 256,
    parameter type axi_ssr_ax_chan_t  = axi_pack_pkg::ax_chan_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [AddrWidth-1:0]  desc_addr_i,
    input  axi_pack_pkg::stride_t desc_stride_i,
    input  axi_pkg::size_t        desc_size_i,
    input  logic [CntWidth-1:0]   desc_num_i,
    input  logic [AxiIdWidth-1:0] desc_id_i,
    output axi_ssr_ax_chan_t      ax_chan_o,
    output logic                  ax_valid_o,
    input  logic                  ax_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned LogStrb    = $clog2(StrbWidth);
    localparam int unsigned BurstBytes = MaxBeats * StrbWidth;
    localparam axi_pkg::size_t MaxSize = axi_pkg::size_t'(LogStrb);

    // Elements in the next burst: everything left, capped at a full burst.
    function automatic logic [CntWidth-1:0] burst_elems(
        input logic [CntWidth-1:0] rem,
        input axi_pkg::size_t      size
    );
        logic [CntWidth-1:0] cap;
        cap = CntWidth'(BurstBytes >> size);
        return (rem < cap) ? rem : cap;
    endfunction

    // Beats minus one; a partly filled last beat still costs a beat.
    function automatic logic [7:0] burst_len(
        input logic [CntWidth-1:0] elems,
        input axi_pkg::size_t      size
    );
        int unsigned         sh;
        logic [CntWidth-1:0] beats;
        sh    = LogStrb - 32'(size);
        beats = (elems + CntWidth'((32'd1 << sh) - 32'd1)) >> sh;
        return 8'(beats - CntWidth'(1));
    endfunction

    // Signed stride step, wrapping in the address space.
    function automatic logic [AddrWidth-1:0] next_addr(
        input logic [AddrWidth-1:0] addr,
        input logic [CntWidth-1:0]  elems,
        input stride_t              stride
    );
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(elems)
             * {{(AddrWidth-StrideWidth){stride[StrideWidth-1]}}, stride};
        return addr + step;
    endfunction

    function automatic axi_ssr_ax_chan_t build_ax(
        input logic [AddrWidth-1:0]  addr,
        input logic [CntWidth-1:0]   elems,
        input axi_pkg::size_t        size,
        input logic [AxiIdWidth-1:0] id,
        input stride_t               stride
    );
        axi_ssr_ax_chan_t ax;
        ax             = '0;
        ax.id          = id;
        ax.addr        = addr;
        ax.len         = burst_len(elems, size);
        ax.size        = size;
        ax.burst       = axi_pkg::BURST_INCR;
        ax.user.stride = stride;
        return ax;
    endfunction

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [CntWidth-1:0]   rem_q, rem_d;
    stride_t               stride_q, stride_d;
    axi_pkg::size_t        size_q, size_d;
    logic [AxiIdWidth-1:0] id_q, id_d;
    axi_ssr_ax_chan_t      ax_q, ax_d;
    logic                  ax_valid_q, ax_valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CntWidth-1:0]   elems;

    // addr_q/rem_q always describe what follows the burst on ax_q, so a
    // handshake with rem_q == 0 is the final one.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        stride_d   = stride_q;
        size_d     = size_q;
        id_d       = id_q;
        ax_d       = ax_q;
        ax_valid_d = ax_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        elems      = '0;
        unique case (state_q)
            IDLE: begin
                if (desc_valid_i) begin
                    stride_d = desc_stride_i;
                    size_d   = desc_size_i;
                    id_d     = desc_id_i;
                    if (desc_size_i > MaxSize) begin
                        err_d = 1'b1;
                    end else if (desc_num_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        elems      = burst_elems(desc_num_i, desc_size_i);
                        ax_d       = build_ax(desc_addr_i, elems, desc_size_i,
                                              desc_id_i, desc_stride_i);
                        ax_valid_d = 1'b1;
                        addr_d     = next_addr(desc_addr_i, elems,
                                               desc_stride_i);
                        rem_d      = desc_num_i - elems;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ax_ready_i) begin
                    if (rem_q == '0) begin
                        ax_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        elems  = burst_elems(rem_q, size_q);
                        ax_d   = build_ax(addr_q, elems, size_q, id_q,
                                          stride_q);
                        addr_d = next_addr(addr_q, elems, stride_q);
                        rem_d  = rem_q - elems;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            stride_q   <= '0;
            size_q     <= '0;
            id_q       <= '0;
            ax_q       <= '0;
            ax_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            stride_q   <= stride_d;
            size_q     <= size_d;
            id_q       <= id_d;
            ax_q       <= ax_d;
            ax_valid_q <= ax_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign desc_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q == ISSUE);
    assign ax_chan_o    = ax_q;
    assign ax_valid_o   = ax_valid_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_axi_pack_req_split.sv
// Directed and random bench for the strided request splitter.
// Expected bursts come from an element-offset model of the descriptor.
module tb_axi_pack_req_split;
    import axi_pkg::*;
    import axi_pack_pkg::*;

    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ax_chan_t exp_q[$];

    axi_pack_req_split_if #(
        .AddrWidth (AW),
        .AxiIdWidth(IW),
        .CntWidth  (CW),
        .ax_chan_t (ax_chan_t)
    ) bus ();

    axi_pack_req_split #(
        .AddrWidth        (AW),
        .DataWidth        (DW),
        .AxiIdWidth       (IW),
        .CntWidth         (CW),
        .MaxBeats         (MB),
        .axi_ssr_ax_chan_t(ax_chan_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .desc_valid_i (bus.desc_valid),
        .desc_ready_o (bus.desc_ready),
        .desc_addr_i  (bus.desc_addr),
        .desc_stride_i(bus.desc_stride),
        .desc_size_i  (bus.desc_size),
        .desc_num_i   (bus.desc_num),
        .desc_id_i    (bus.desc_id),
        .ax_chan_o    (bus.ax_chan),
        .ax_valid_o   (bus.ax_valid),
        .ax_ready_i   (bus.ax_ready),
        .busy_o       (bus.busy),
        .done_o       (bus.done),
        .err_o        (bus.err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst k starts at element offset 'sent'; its address is the base plus
    // sent*stride, taken modulo the address space.
    function automatic void model(input desc_t d);
        longint unsigned epb, cap, e, sent, len;
        longint          a;
        ax_chan_t        c;
        exp_q.delete();
        if (d.size > 3 || d.num == 0) return;
        epb  = (DW / 8) >> d.size;
        cap  = MB * epb;
        sent = 0;
        while (sent < d.num) begin
            e = (d.num - sent < cap) ? d.num - sent : cap;
            a = longint'(d.addr) + longint'(sent) * longint'($signed(d.stride));
            len = (e + epb - 1) / epb - 1;
            c             = '0;
            c.id          = d.id;
            c.addr        = a[AW-1:0];
            c.len         = len[7:0];
            c.size        = d.size;
            c.burst       = BURST_INCR;
            c.user.stride = d.stride;
            exp_q.push_back(c);
            sent += e;
        end
    endfunction

    task automatic drive_desc(input desc_t d);
        bus.desc_addr   = d.addr;
        bus.desc_stride = d.stride;
        bus.desc_size   = d.size;
        bus.desc_num    = d.num;
        bus.desc_id     = d.id;
    endtask

    task automatic run_desc(input string nm, input desc_t d,
                            input int stall0, input int pct);
        int    cyc;
        desc_t junk;
        model(d);
        chk({nm, ":desc_ready"}, bus.desc_ready, 1'b1);
        drive_desc(d);
        bus.desc_valid = 1'b1;
        @(negedge clk);
        bus.desc_valid = 1'b0;
        if (d.size > 3) begin
            chk({nm, ":err"}, bus.err, 1'b1);
            chk({nm, ":err_valid"}, bus.ax_valid, 1'b0);
            @(negedge clk);
            chk({nm, ":err_clr"}, bus.err, 1'b0);
            chk({nm, ":err_valid2"}, bus.ax_valid, 1'b0);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({nm, ":zdone"}, bus.done, 1'b1);
            chk({nm, ":zvalid"}, bus.ax_valid, 1'b0);
            chk({nm, ":zready"}, bus.desc_ready, 1'b1);
            @(negedge clk);
            chk({nm, ":zdone_clr"}, bus.done, 1'b0);
            return;
        end
        chk({nm, ":busy"}, bus.busy, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 2000) begin
                chk({nm, ":timeout"}, 128'(exp_q.size()), 128'd0);
                exp_q.delete();
                break;
            end
            chk({nm, ":valid"}, bus.ax_valid, 1'b1);
            chk({nm, ":chan"}, bus.ax_chan, exp_q[0]);
            chk({nm, ":no_done"}, bus.done, 1'b0);
            chk({nm, ":rdy_low"}, bus.desc_ready, 1'b0);
            if (cyc < stall0 || $urandom_range(99) < pct) begin
                bus.ax_ready   = 1'b0;
                junk           = desc_t'({$urandom, $urandom, $urandom, $urandom});
                drive_desc(junk);
                bus.desc_valid = 1'b1;
            end else begin
                bus.ax_ready   = 1'b1;
                bus.desc_valid = 1'b0;
                void'(exp_q.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        bus.ax_ready   = 1'b0;
        bus.desc_valid = 1'b0;
        chk({nm, ":done"}, bus.done, 1'b1);
        chk({nm, ":end_valid"}, bus.ax_valid, 1'b0);
        chk({nm, ":end_busy"}, bus.busy, 1'b0);
        chk({nm, ":end_ready"}, bus.desc_ready, 1'b1);
        @(negedge clk);
        chk({nm, ":done_clr"}, bus.done, 1'b0);
    endtask

    initial begin
        desc_t d1, d2, d;
        bus.desc_valid = 1'b0;
        bus.ax_ready   = 1'b0;
        drive_desc('0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset:valid", bus.ax_valid, 1'b0);
        chk("reset:busy", bus.busy, 1'b0);
        chk("reset:done", bus.done, 1'b0);
        chk("reset:err", bus.err, 1'b0);
        rst = 1'b0;
        chk("reset:ready", bus.desc_ready, 1'b1);

        d1 = '{addr: 48'h1000, stride: 32'sd8, size: 3'd2,
               num: 32'd19, id: 4'd3};
        d2 = '{addr: 48'h2000, stride: -32'sd4, size: 3'd3,
               num: 32'd5, id: 4'd9};

        run_desc("s1", d1, 0, 0);
        run_desc("s2", d2, 0, 0);
        run_desc("s3stall", d1, 5, 0);
        d = d1;
        d.num = 0;
        run_desc("s4zero", d, 0, 0);
        d = d1;
        d.size = 3'd4;
        run_desc("s5illegal", d, 0, 0);

        model(d1);
        drive_desc(d1);
        bus.desc_valid = 1'b1;
        @(negedge clk);
        bus.desc_valid = 1'b0;
        chk("rst:b0", bus.ax_chan, exp_q[0]);
        bus.ax_ready = 1'b1;
        @(negedge clk);
        chk("rst:b1", bus.ax_chan, exp_q[1]);
        bus.ax_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst:valid", bus.ax_valid, 1'b0);
        chk("rst:busy", bus.busy, 1'b0);
        chk("rst:done", bus.done, 1'b0);
        chk("rst:ready", bus.desc_ready, 1'b1);
        @(negedge clk);
        chk("rst:no_done", bus.done, 1'b0);
        chk("rst:idle_valid", bus.ax_valid, 1'b0);
        exp_q.delete();

        for (int i = 0; i < 30; i++) begin
            d.addr   = {16'($urandom), 32'($urandom)};
            d.stride = $signed(32'($urandom_range(0, 600)) - 32'd300);
            if (i % 5 == 4) d.stride = $signed($urandom);
            d.size   = 3'($urandom_range(0, 4));
            d.num    = 32'($urandom_range(0, 100));
            d.id     = 4'($urandom);
            run_desc("rnd", d, 0, 30);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_pack_req_split.md
AXI_PACK_REQ_SPLIT -- requirements
Module: axi_pack_req_split

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AddrWidth, 48, address width.
- DataWidth, 64, packed data bus width in bits (power of two, at least 64).
- AxiIdWidth, 4, ID width.
- CntWidth, 32, element-count width.
- MaxBeats, 256, maximum beats per burst (power of two, 1..256).
- axi_ssr_ax_chan_t, logic, packed-AXI AW/AR channel type.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- desc_valid_i, in, 1, descriptor valid.
- desc_ready_o, out, 1, descriptor ready.
- desc_addr_i, in, AddrWidth, base address of element 0.
- desc_stride_i, in, axi_pack_pkg::stride_t, signed byte stride between elements.
- desc_size_i, in, axi_pkg::size_t, log2 of element bytes.
- desc_num_i, in, CntWidth, element count.
- desc_id_i, in, AxiIdWidth, AXI ID for all bursts.
- ax_chan_o, out, axi_ssr_ax_chan_t, packed request to the pack converter.
- ax_valid_o, out, 1, request valid.
- ax_ready_i, in, 1, request ready.
- busy_o, out, 1, descriptor in progress.
- done_o, out, 1, one-cycle pulse when a descriptor completes.
- err_o, out, 1, one-cycle pulse when an illegal descriptor is dropped.

Function
REQ-004 The block SHALL implement a two-state FSM with states IDLE and ISSUE.
REQ-005 In IDLE, desc_ready_o SHALL be 1; in ISSUE it SHALL be 0.
REQ-006 A descriptor handshake SHALL register every descriptor field; ax_valid_o SHALL rise in the following cycle, so latency is 1 cycle.
REQ-007 Elements per beat: EPB = (DataWidth/8) >> desc_size_i.
REQ-008 Each burst SHALL carry E = min(remaining, MaxBeats*EPB) elements.
REQ-009 Each burst SHALL set len = ceil(E/EPB)-1, with size, id and addr taken from the registered descriptor and internal counters.
REQ-010 The stride SHALL be carried in user.stride; burst SHALL be INCR; all other fields SHALL be 0.
REQ-011 After each AX handshake, the next addr SHALL be addr + E*stride, sign-extended, wrapping modulo 2^AddrWidth, and remaining SHALL become remaining-E.
REQ-012 ax_chan_o SHALL be registered and held stable while ax_valid_o=1 and ax_ready_i=0; ax_valid_o SHALL NOT drop without a handshake.
REQ-013 Back-to-back bursts SHALL issue at one per cycle while ax_ready_i=1.
REQ-014 On the handshake of the final burst (remaining reaches 0), the FSM SHALL return to IDLE and done_o SHALL pulse in the next cycle.
REQ-015 A descriptor with desc_num_i=0 SHALL be accepted, SHALL produce no burst, and SHALL pulse done_o in the cycle after the handshake.
REQ-016 A descriptor with desc_size_i > log2(DataWidth/8) SHALL be accepted and dropped, with err_o pulsed in the next cycle and no burst issued.
REQ-017 busy_o SHALL equal (state == ISSUE).
REQ-018 desc_valid_i while in ISSUE SHALL be ignored; the descriptor waits because desc_ready_o=0.

Reset
REQ-019 While rst_i=1 at a clock edge, the state SHALL become IDLE and ax_valid_o, busy_o, done_o and err_o SHALL be 0; desc_ready_o SHALL be 1 from the next cycle.
REQ-020 A reset during ISSUE SHALL abandon the descriptor without completing the pending AX handshake, and no done_o pulse SHALL follow.

Structure
REQ-021 stride_t and ssr_user_t SHALL come from axi_pack_pkg, and a desc_t typedef (addr, stride, size, num, id) SHALL be added to axi_pack_pkg.
REQ-022 The block SHALL be a single module with no sub-modules; the burst-element computation SHALL be one combinational function.

Verification
REQ-023 The bench SHALL use DataWidth=64, MaxBeats=4 and cover these directed scenarios:
- addr=0x1000, stride=8, size=2, num=19, ready held 1 -> bursts (0x1000,len3), (0x1040,len3), (0x1080,len1) on consecutive cycles, then a done_o pulse.
- addr=0x2000, stride=-4, size=3, num=5 -> bursts (0x2000,len3), (0x1FF0,len0), with user.stride=-4.
- Same as the first scenario with ax_ready_i=0 for 5 cycles -> ax_chan_o and ax_valid_o stable across all 5 cycles, identical burst sequence afterwards.
- num=0 -> no ax_valid_o, done_o pulses 1 cycle after the handshake, desc_ready_o back to 1.
- size=4 -> err_o pulse, no ax_valid_o; rst_i asserted after the first burst of the first scenario -> ax_valid_o=0 and desc_ready_o=1 in the next cycle, no done_o.
